// File: rtl/jtag_data_reg.sv
// JTAG data register: WIDTH-bit capture/shift chain with a shadow update register.
// Updates are optionally gated by an exact shift-count check and flagged toward the core.
module jtag_data_reg #(
    parameter int unsigned       WIDTH      = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL  = '0,
    parameter bit                STRICT_LEN = 1'b1
) (
    input  logic             tck_i,
    input  logic             trst_ni,
    input  logic             sel_i,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             update_i,
    input  logic             tdi_i,
    output logic             tdo_o,
    input  logic [WIDTH-1:0] capture_data_i,
    output logic [WIDTH-1:0] update_data_o,
    output logic             update_valid_o,
    output logic             length_err_o
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH + 1);

    logic [WIDTH-1:0] chain_q, chain_d;
    logic [WIDTH-1:0] upd_q, upd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] chain_shifted;
    logic             upd_accept;

    generate
        if (WIDTH == 1) begin : g_shift_1
            assign chain_shifted = tdi_i;
        end else begin : g_shift_n
            assign chain_shifted = {tdi_i, chain_q[WIDTH-1:1]};
        end
    endgenerate

    assign upd_accept = !STRICT_LEN || (cnt_q == CNT_FULL);

    // Strobe priority: capture > shift > update; nothing acts while deselected.
    always_comb begin
        chain_d = chain_q;
        upd_d   = upd_q;
        cnt_d   = cnt_q;
        vld_d   = 1'b0;
        err_d   = err_q;
        if (sel_i) begin
            if (capture_i) begin
                chain_d = capture_data_i;
                cnt_d   = '0;
            end else if (shift_i) begin
                chain_d = chain_shifted;
                // Saturate rather than wrap so an overshift can never alias to WIDTH.
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end else if (update_i) begin
                if (upd_accept) begin
                    upd_d = chain_q;
                    vld_d = 1'b1;
                    err_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            chain_q <= RESET_VAL;
            upd_q   <= RESET_VAL;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            chain_q <= chain_d;
            upd_q   <= upd_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign tdo_o          = chain_q[0];
    assign update_data_o  = upd_q;
    assign update_valid_o = vld_q;
    assign length_err_o   = err_q;

endmodule

// File: doc/jtag_data_reg.md
Name: jtag_data_reg

Overview:
- Parametrised JTAG data register: WIDTH-bit capture/shift chain plus a shadow update register, driven by TAP controller strobes.
- Generalised successor of the single-bit scan cell. Adds configurable width, reset value, shift-length checking and an update-valid pulse toward the core.
- Sits between the TAP controller / IR decode and core-side debug or config logic. One instance per selectable DR.

Parameters:
- WIDTH, 8, number of bits in the shift chain and update register (>=1).
- RESET_VAL, '0, reset value of the shift chain and of update_data_o (WIDTH bits).
- STRICT_LEN, 1, 1 = update is accepted only after exactly WIDTH shift cycles; 0 = update is always accepted.

Ports:
- tck_i  in  1  JTAG clock; all state changes on the rising edge.
- trst_ni  in  1  TAP reset, asynchronous, active-low.
- sel_i  in  1  register selected by the current IR; all strobes are ignored when low.
- capture_i  in  1  Capture-DR strobe.
- shift_i  in  1  Shift-DR strobe.
- update_i  in  1  Update-DR strobe.
- tdi_i  in  1  serial data in.
- tdo_o  out  1  serial data out, equal to chain bit 0.
- capture_data_i  in  WIDTH  parallel data loaded on capture.
- update_data_o  out  WIDTH  shadow register; holds the last accepted update.
- update_valid_o  out  1  one-cycle pulse on each accepted update.
- length_err_o  out  1  sticky flag: an update was rejected because of a wrong shift count.

Behaviour:
- Reset is asynchronous and active-low (trst_ni). While trst_ni = 0:
  - chain = RESET_VAL
  - update_data_o = RESET_VAL
  - update_valid_o = 0
  - length_err_o = 0
  - shift count = 0
  - tdo_o = RESET_VAL[0]
- Reset deassertion takes effect at the first rising tck_i edge after trst_ni rises.
- Shift counter: width $clog2(WIDTH+2). It saturates at WIDTH+1 and never wraps, so an overshift stays detectable.
- Strobe handling applies only when sel_i = 1. Priority if several strobes are asserted together: capture > shift > update. Only the highest-priority strobe acts.
- Capture:
  - chain <= capture_data_i
  - count <= 0
  - length_err_o is unchanged
- Shift:
  - chain <= {tdi_i, chain[WIDTH-1:1]}, i.e. LSB out first, tdi_i enters the MSB.
  - count <= min(count+1, WIDTH+1).
- Update, accepted when STRICT_LEN = 0 or count == WIDTH:
  - update_data_o <= chain
  - update_valid_o = 1 for exactly the next cycle
  - length_err_o <= 0
- Update, rejected otherwise:
  - update_data_o unchanged
  - no pulse
  - length_err_o <= 1
- Update does not change the chain or the count. A repeated update strobe with no shifts in between re-evaluates the same count.
- update_valid_o is registered. It is high for one tck_i cycle after the accepting edge and low in every other cycle, including back-to-back updates separated by idle cycles.
- sel_i = 0: chain, count, update_data_o and length_err_o all hold; update_valid_o = 0. tdo_o still shows chain[0]; the TAP output mux handles deselection.
- WIDTH = 1: shift replaces chain[0] with tdi_i. With STRICT_LEN = 1, exactly one shift is required before update.
- Reset asserted mid-shift or mid-update: all state returns to reset values immediately. No partial update may reach update_data_o.
- tdo_o is combinational from chain[0] with no extra register. TAP-level negedge retiming is outside this block.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5, pulse trst_ni low -> update_data_o=8'hA5, tdo_o=1, update_valid_o=0, length_err_o=0.
- Capture then 8 shifts: capture_data_i=8'h3C, capture, then 8 shifts with tdi=1,0,1,0,1,1,0,0 -> tdo sequence 0,0,1,1,1,1,0,0. Chain = 8'h35; update -> update_data_o=8'h35 and a one-cycle update_valid_o pulse.
- Short shift: STRICT_LEN=1, capture, 7 shifts, update -> update_data_o unchanged, no pulse, length_err_o=1. Then capture, 8 shifts of 8'hFF, update -> update_data_o=8'hFF, length_err_o=0.
- Overshift: STRICT_LEN=1, capture, 12 shifts, update -> rejected, length_err_o=1, count saturated at 9. STRICT_LEN=0, same stimulus -> accepted with the last 8 shifted bits.
- Deselect and priority: sel_i=0 with all strobes active for 5 cycles -> no state change, no pulse. sel_i=1 with capture and shift asserted together -> chain = capture_data_i, count = 0.
- Reset mid-shift: after 4 shifts, assert trst_ni low for one cycle, then update -> update_data_o=RESET_VAL, length_err_o=1 (count 0 != 8), no pulse.
